// File: rtl/cp_mux2_rr_arbiter_if.sv
// cp_mux2_rr_arbiter_if
// Handshake and data bundle for the two-source round-robin arbiter.
//   Source k (k = 0, 1): i_validk, i_datak, i_lastk in; o_readyk out.
//   Output stage: o_valid, o_data, o_last, o_sel, o_mux_en out; i_out_ready in.
// The slave modport is the arbiter's view. The master modport is the view of the
// sources and sink around it.
interface cp_mux2_rr_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid0;
    logic [DATA_WIDTH-1:0] i_data0;
    logic                  i_last0;
    logic                  o_ready0;
    logic                  i_valid1;
    logic [DATA_WIDTH-1:0] i_data1;
    logic                  i_last1;
    logic                  o_ready1;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;
    logic                  i_out_ready;
    logic                  o_sel;
    logic                  o_mux_en;

    modport slave (
        input  i_valid0, i_data0, i_last0,
        output o_ready0,
        input  i_valid1, i_data1, i_last1,
        output o_ready1,
        output o_valid, o_data, o_last, o_sel, o_mux_en,
        input  i_out_ready
    );

    modport master (
        output i_valid0, i_data0, i_last0,
        input  o_ready0,
        output i_valid1, i_data1, i_last1,
        input  o_ready1,
        input  o_valid, o_data, o_last, o_sel, o_mux_en,
        output i_out_ready
    );
endinterface

// File: rtl/cp_mux2_rr_arbiter.sv
// cp_mux2_rr_arbiter
// Two-source round-robin arbiter. The winning source goes through a 2:1 select
// into a single registered output stage. A grant stays locked for the whole burst.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      cp_mux2_rr_arbiter_if.slave: two source handshakes, output stage
//            handshake, and the mux control pair (o_sel, o_mux_en)
//
// state | meaning
// IDLE  | no burst open; arbitrate between valid sources, ties go to rr_ptr
// LOCK0 | source 0 is mid-burst; only source 0 may be granted
// LOCK1 | source 1 is mid-burst; only source 1 may be granted
module cp_mux2_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int RR_INIT    = 0
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    cp_mux2_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                state;
    logic                  rr_ptr;
    logic                  valid_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  last_r;
    logic                  sel_r;
    logic                  mux_en_r;

    logic load;
    logic grant_vld;
    logic grant_idx;
    logic accept0;
    logic accept1;

    // The output register can take a new beat when it is empty or is draining now.
    assign load = ~valid_r | bus.i_out_ready;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        case (state)
            LOCK0: begin
                grant_vld = 1'b1;
                grant_idx = 1'b0;
            end
            LOCK1: begin
                grant_vld = 1'b1;
                grant_idx = 1'b1;
            end
            default: begin
                if (bus.i_valid0 && bus.i_valid1) begin
                    grant_vld = 1'b1;
                    grant_idx = rr_ptr;
                end else if (bus.i_valid0) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b0;
                end else if (bus.i_valid1) begin
                    grant_vld = 1'b1;
                    grant_idx = 1'b1;
                end
            end
        endcase
    end

    // Gating with i_rst_n keeps both readies low for the whole time reset is held.
    // Without it the IDLE grant would reach the ready outputs while in reset.
    assign bus.o_ready0 = i_rst_n & load & grant_vld & ~grant_idx;
    assign bus.o_ready1 = i_rst_n & load & grant_vld &  grant_idx;

    assign accept0 = bus.i_valid0 & bus.o_ready0;
    assign accept1 = bus.i_valid1 & bus.o_ready1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            rr_ptr   <= 1'(RR_INIT);
            valid_r  <= 1'b0;
            data_r   <= '0;
            last_r   <= 1'b0;
            sel_r    <= 1'b0;
            mux_en_r <= 1'b1;
        end else if (accept0) begin
            valid_r  <= 1'b1;
            mux_en_r <= 1'b0;
            data_r   <= bus.i_data0;
            last_r   <= bus.i_last0;
            sel_r    <= 1'b0;
            if (bus.i_last0) begin
                state  <= IDLE;
                rr_ptr <= 1'b1;
            end else begin
                state  <= LOCK0;
            end
        end else if (accept1) begin
            valid_r  <= 1'b1;
            mux_en_r <= 1'b0;
            data_r   <= bus.i_data1;
            last_r   <= bus.i_last1;
            sel_r    <= 1'b1;
            if (bus.i_last1) begin
                state  <= IDLE;
                rr_ptr <= 1'b0;
            end else begin
                state  <= LOCK1;
            end
        end else if (bus.i_out_ready) begin
            // Drain with no replacement: data, last and sel keep their values for the bus keeper.
            valid_r  <= 1'b0;
            mux_en_r <= 1'b1;
        end
    end

    assign bus.o_valid  = valid_r;
    assign bus.o_data   = data_r;
    assign bus.o_last   = last_r;
    assign bus.o_sel    = sel_r;
    assign bus.o_mux_en = mux_en_r;
endmodule

// File: tb/tb_cp_mux2_rr_arbiter.sv
module tb_cp_mux2_rr_arbiter;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    cp_mux2_rr_arbiter_if #(.DATA_WIDTH(32)) bus ();

    cp_mux2_rr_arbiter #(.DATA_WIDTH(32), .RR_INIT(0)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.i_valid0    = 1'b1;
        bus.i_data0     = $urandom;
        bus.i_last0     = 1'b0;
        bus.i_valid1    = 1'b1;
        bus.i_data1     = $urandom;
        bus.i_last1     = 1'b1;
        bus.i_out_ready = 1'b1;

        // Reset is held while the inputs are random and active.
        step();
        step();
        chk("rst_valid",  32'(bus.o_valid),  32'd0);
        chk("rst_data",   bus.o_data,        32'd0);
        chk("rst_sel",    32'(bus.o_sel),    32'd0);
        chk("rst_mux_en", 32'(bus.o_mux_en), 32'd1);
        chk("rst_ready0", 32'(bus.o_ready0), 32'd0);
        chk("rst_ready1", 32'(bus.o_ready1), 32'd0);

        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        #3 rst_n = 1'b1;
        #1;
        chk("rel_ready0_novalid", 32'(bus.o_ready0), 32'd0);
        bus.i_valid0 = 1'b1;
        bus.i_data0  = 32'h0000_0000;
        bus.i_last0  = 1'b1;
        #1;
        chk("rel_ready0_valid", 32'(bus.o_ready0), 32'd1);

        // Alternating single beats, both sources always valid.
        bus.i_valid1 = 1'b1;
        bus.i_data1  = 32'h0000_0001;
        bus.i_last1  = 1'b1;
        #1;
        chk("alt_pre_ready0", 32'(bus.o_ready0), 32'd1);
        chk("alt_pre_ready1", 32'(bus.o_ready1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("alt_data%0d", i), bus.o_data,        32'(i % 2));
            chk($sformatf("alt_sel%0d", i),  32'(bus.o_sel),    32'(i % 2));
            chk($sformatf("alt_men%0d", i),  32'(bus.o_mux_en), 32'd0);
        end
        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        step();
        chk("alt_drain_valid", 32'(bus.o_valid),  32'd0);
        chk("alt_drain_men",   32'(bus.o_mux_en), 32'd1);
        chk("alt_drain_hold",  bus.o_data,        32'd1);

        // Source 0 sends a 3-beat burst while source 1 stays valid.
        bus.i_valid1 = 1'b1;
        bus.i_data1  = 32'h0000_00B0;
        bus.i_last1  = 1'b1;
        bus.i_valid0 = 1'b1;
        bus.i_data0  = 32'h0000_00A0;
        bus.i_last0  = 1'b0;
        #1;
        chk("burst_r1_a0", 32'(bus.o_ready1), 32'd0);
        chk("burst_r0_a0", 32'(bus.o_ready0), 32'd1);
        step();
        bus.i_data0 = 32'h0000_00A1;
        #1;
        chk("burst_d_a0",  bus.o_data,        32'h0000_00A0);
        chk("burst_r1_a1", 32'(bus.o_ready1), 32'd0);
        step();
        bus.i_data0 = 32'h0000_00A2;
        bus.i_last0 = 1'b1;
        #1;
        chk("burst_d_a1",  bus.o_data,        32'h0000_00A1);
        chk("burst_r1_a2", 32'(bus.o_ready1), 32'd0);
        step();
        bus.i_valid0 = 1'b0;
        #1;
        chk("burst_d_a2",    bus.o_data,        32'h0000_00A2);
        chk("burst_last_a2", 32'(bus.o_last),   32'd1);
        chk("burst_r1_free", 32'(bus.o_ready1), 32'd1);
        step();
        chk("burst_d_b0",   bus.o_data,     32'h0000_00B0);
        chk("burst_sel_b0", 32'(bus.o_sel), 32'd1);

        // Backpressure while the output register holds B0.
        bus.i_out_ready = 1'b0;
        bus.i_valid0 = 1'b1;
        bus.i_data0  = 32'h0000_00C0;
        bus.i_last0  = 1'b1;
        bus.i_valid1 = 1'b1;
        bus.i_data1  = 32'h0000_00D0;
        bus.i_last1  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_r0_%0d", i),  32'(bus.o_ready0), 32'd0);
            chk($sformatf("bp_r1_%0d", i),  32'(bus.o_ready1), 32'd0);
            chk($sformatf("bp_d_%0d", i),   bus.o_data,        32'h0000_00B0);
            chk($sformatf("bp_sel_%0d", i), 32'(bus.o_sel),    32'd1);
            chk($sformatf("bp_v_%0d", i),   32'(bus.o_valid),  32'd1);
            step();
        end
        bus.i_valid0 = 1'b0;
        bus.i_valid1 = 1'b0;
        bus.i_out_ready = 1'b1;
        step();
        chk("bp_drain_valid", 32'(bus.o_valid),  32'd0);
        chk("bp_drain_men",   32'(bus.o_mux_en), 32'd1);

        // Source 1 opens a burst and then stalls while source 0 waits.
        bus.i_valid1 = 1'b1;
        bus.i_data1  = 32'h0000_00E0;
        bus.i_last1  = 1'b0;
        step();
        bus.i_valid1 = 1'b0;
        bus.i_valid0 = 1'b1;
        bus.i_data0  = 32'h0000_00F0;
        bus.i_last0  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("stall_r0_%0d", i),  32'(bus.o_ready0), 32'd0);
            chk($sformatf("stall_d_%0d", i),   bus.o_data,        32'h0000_00E0);
            chk($sformatf("stall_sel_%0d", i), 32'(bus.o_sel),    32'd1);
            step();
        end
        bus.i_valid1 = 1'b1;
        bus.i_data1  = 32'h0000_00E1;
        bus.i_last1  = 1'b1;
        #1;
        chk("stall_end_r1", 32'(bus.o_ready1), 32'd1);
        chk("stall_end_r0", 32'(bus.o_ready0), 32'd0);
        step();
        bus.i_valid1 = 1'b0;
        #1;
        chk("stall_d_e1",  bus.o_data,        32'h0000_00E1);
        chk("stall_r0_go", 32'(bus.o_ready0), 32'd1);
        step();
        bus.i_valid0 = 1'b0;
        chk("stall_d_f0",   bus.o_data,     32'h0000_00F0);
        chk("stall_sel_f0", 32'(bus.o_sel), 32'd0);

        // Async reset in the middle of a source 1 burst. The pointer is at 1 before
        // the reset, so a source 0 win afterwards shows the pointer was re-initialised.
        bus.i_valid1 = 1'b1;
        bus.i_data1  = 32'h0000_0090;
        bus.i_last1  = 1'b0;
        step();
        chk("arst_pre_valid", 32'(bus.o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.o_valid),  32'd0);
        chk("arst_men",   32'(bus.o_mux_en), 32'd1);
        chk("arst_data",  bus.o_data,        32'd0);
        bus.i_valid0 = 1'b1;
        bus.i_data0  = 32'h0000_0091;
        bus.i_last0  = 1'b1;
        bus.i_data1  = 32'h0000_0092;
        bus.i_last1  = 1'b1;
        #1 rst_n = 1'b1;
        #1;
        chk("arst_r0", 32'(bus.o_ready0), 32'd1);
        chk("arst_r1", 32'(bus.o_ready1), 32'd0);
        step();
        chk("arst_d",   bus.o_data,     32'h0000_0091);
        chk("arst_sel", 32'(bus.o_sel), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cp_mux2_rr_arbiter.md
Name: cp_mux2_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer that shares one 32-bit data path between source 0 and source 1.
- Each source hands beats over on a valid/ready handshake. The block picks a winner, steers it through the 2:1 select, and registers the result into a single output stage with its own valid/ready handshake.
- Supports multi-beat bursts: a grant is locked until the source's last beat.
- Exports the mux control pair (select, active-high tristate enable) so the downstream 2:1 mux and bus-keeper logic can track it.

Parameters:
- DATA_WIDTH, 32, width of both input buses and the output bus.
- RR_INIT, 0, requester favoured first after reset (0 or 1).

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid0  input  1  source 0 has a beat on i_data0.
- i_data0  input  DATA_WIDTH  source 0 beat data.
- i_last0  input  1  source 0 beat is the final beat of its burst.
- o_ready0  output  1  source 0 beat accepted this cycle when high together with i_valid0 (combinational).
- i_valid1  input  1  source 1 has a beat on i_data1.
- i_data1  input  DATA_WIDTH  source 1 beat data.
- i_last1  input  1  source 1 beat is the final beat of its burst.
- o_ready1  output  1  source 1 handshake ready (combinational).
- o_valid  output  1  output register holds a beat.
- o_data  output  DATA_WIDTH  registered beat data.
- o_last  output  1  registered last flag.
- i_out_ready  input  1  downstream accepts o_data this cycle.
- o_sel  output  1  source of the beat in the output register (0 = data0, 1 = data1), registered.
- o_mux_en  output  1  mux tristate enable, active high: 1 = bus high-Z/idle, equals ~o_valid.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_valid=0, o_data=0, o_last=0, o_sel=0, o_mux_en=1.
  - FSM=IDLE; RR pointer=RR_INIT.
  - o_ready0/1 are 0 while in reset.
  - Reset mid-burst discards the held beat and clears the lock. There is no recovery of the dropped beat.
- Load condition: load = ~o_valid | i_out_ready. Both o_ready signals are 0 when load=0.
- Grant (combinational, one of: none, 0, 1):
  - LOCK0: grant 0. LOCK1: grant 1.
  - IDLE, single valid: grant that source.
  - IDLE, both valid: grant the RR pointer's source.
  - IDLE, none valid: no grant.
- Ready: o_readyk = load & (grant==k). An unselected source sees ready=0 and must hold valid and data stable.
- Accept (i_validk & o_readyk) at edge:
  - o_data <= i_datak; o_last <= i_lastk; o_sel <= k; o_valid <= 1.
  - If i_lastk=1: FSM <= IDLE; RR pointer <= ~k.
  - If i_lastk=0: FSM <= LOCKk; pointer unchanged.
- Drain: i_out_ready=1 with no accept in the same cycle: o_valid <= 0, and o_data, o_last, o_sel hold their last values.
- Simultaneous drain and accept: new beat replaces the old one. o_valid stays 1, giving full throughput of 1 beat/cycle.
- Latency: accepted beat appears on o_data one cycle after the accept edge.
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE->LOCKk on accepting a non-last beat from k.
  - LOCKk->IDLE on accepting a last beat from k.
  - In LOCKk, i_validk=0 stalls the block; the other source is never granted until the burst ends. This is a deliberate burst-atomicity rule.
- Single-beat transfer: i_last=1 on the first beat; FSM stays IDLE and the pointer flips.
- Pointer moves only on burst completion, never on an idle cycle.
- o_mux_en = ~o_valid, driven from the register (glitch-free).
- o_sel changes only on accept edges.
- Widths: data passes through unmodified; no arithmetic.

Test Plan:
- Reset value check: hold i_rst_n=0 with random inputs, then release. Required: o_valid=0, o_data=0, o_sel=0, o_mux_en=1, o_ready0=o_ready1=0 during reset. After release, o_ready0=1 only when i_valid0=1.
- Alternating single beats: both sources continuously valid with last=1, data0=32'h0000_0000, data1=32'h0000_0001, i_out_ready=1. Required (RR_INIT=0): o_data sequence 0,1,0,1,… with o_sel toggling every cycle; first output one cycle after release.
- Burst lock: source 0 sends 3 beats (A0,A1,A2, last on A2) while source 1 is valid throughout. Required: o_ready1=0 for all three cycles; o_data = A0,A1,A2, then source 1's beat.
- Backpressure: i_out_ready=0 for 5 cycles with o_valid=1. Required: o_data and o_sel stable, o_ready0=o_ready1=0. i_out_ready=1 with both sources idle gives o_valid=0 and o_mux_en=1 next cycle.
- Lock stall: source 1 sends a non-last beat, then drops i_valid1 for 4 cycles while i_valid0=1. Required: no source 0 grant. Source 1's last beat then completes the burst, and source 0 is granted on the next load cycle.
- Async reset mid-burst: assert i_rst_n=0 between clock edges during LOCK1. Required: o_valid drops immediately (no clock edge). After release the FSM is in IDLE and source 0 wins a simultaneous request.
